// File: rtl/uart_program_loader.sv
// uart_program_loader: receives a framed program image over UART 8N1 and writes it into CPU RAM,
// holding the CPU while loading and pulsing a restart after a checksum-verified image.
module uart_program_loader #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int CLK_FREQ_HZ    = 27000000,
    parameter int BAUD           = 115200,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  uart_rx,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  cpu_hold,
    output logic                  cpu_restart,
    output logic                  busy,
    output logic [1:0]            err
);
    localparam int DIV   = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
    localparam int BPW   = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;
    localparam int CW    = $clog2(DIV);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERROR} state_t;

    rx_state_t             rs_q, rs_d;
    logic [2:0]            sync_q, sync_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            sh_q, sh_d;
    logic                  rxv_q, rxv_d, rxf_q, rxf_d;
    state_t                st_q, st_d;
    logic [LW-1:0]         len_q, len_d, widx_q, widx_d;
    logic [1:0]            bidx_q, bidx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d, wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            csum_q, csum_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  we_q, we_d, hold_q, hold_d;
    logic [1:0]            err_q, err_d;
    logic                  in_frame;

    assign in_frame    = st_q inside {LEN, DATA, CSUM};
    assign ram_we      = we_q;
    assign ram_addr    = waddr_q;
    assign ram_wdata   = wdata_q;
    assign cpu_hold    = hold_q;
    assign cpu_restart = st_q == DONE;
    assign busy        = in_frame;
    assign err         = err_q;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection
    always_comb begin
        sync_d = {sync_q[1:0], uart_rx};
        rs_d   = rs_q;
        cnt_d  = cnt_q + CW'(1);
        bit_d  = bit_q;
        sh_d   = sh_q;
        rxv_d  = 1'b0;
        rxf_d  = 1'b0;
        case (rs_q)
            R_IDLE: begin
                cnt_d = '0;
                rs_d  = (sync_q[2] && !sync_q[1]) ? R_START : R_IDLE;
            end
            R_START: if (cnt_q == CW'(DIV / 2 - 1)) begin
                cnt_d = '0;
                bit_d = '0;
                rs_d  = sync_q[1] ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt_q == CW'(DIV - 1)) begin
                cnt_d = '0;
                sh_d  = {sync_q[1], sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                rs_d  = (bit_q == 3'd7) ? R_STOP : R_DATA;
            end
            default: if (cnt_q == CW'(DIV - 1)) begin
                rxv_d = sync_q[1];
                rxf_d = !sync_q[1];
                rs_d  = R_IDLE;
            end
        endcase
    end

    always_comb begin
        st_d    = st_q;
        len_d   = len_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        hold_d  = hold_q;
        err_d   = err_q;
        tmo_d   = (in_frame && !rxv_q) ? tmo_q + TW'(1) : '0;
        case (st_q)
            IDLE: if (rxv_q && sh_q == 8'hA5) begin
                st_d   = LEN;
                hold_d = 1'b1;
                err_d  = 2'd0;
                csum_d = '0;
                widx_d = '0;
                bidx_d = '0;
            end
            LEN: if (rxv_q) begin
                len_d = (sh_q == 8'd0 || int'(sh_q) >= DEPTH) ? LW'(DEPTH) : LW'(sh_q);
                st_d  = DATA;
            end
            DATA: if (rxv_q) begin
                word_d[8*bidx_q +: 8] = sh_q;
                csum_d = csum_q + sh_q;
                bidx_d = bidx_q + 2'd1;
                if (bidx_q == 2'(BPW - 1)) begin
                    we_d    = 1'b1;
                    wdata_d = word_d;
                    waddr_d = widx_q[ADDR_WIDTH-1:0];
                    widx_d  = widx_q + LW'(1);
                    bidx_d  = '0;
                    st_d    = (widx_q + LW'(1) == len_q) ? CSUM : DATA;
                end
            end
            CSUM: if (rxv_q) begin
                st_d   = (sh_q == csum_q) ? DONE : ERROR;
                err_d  = (sh_q == csum_q) ? err_q : 2'd3;
                hold_d = sh_q != csum_q;
            end
            default: st_d = IDLE;
        endcase
        if (in_frame && rxf_q) begin
            st_d  = ERROR;
            err_d = 2'd1;
        end
        if (in_frame && !rxv_q && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            st_d  = ERROR;
            err_d = 2'd2;
        end
        // disarming wins over everything but leaves the status untouched
        if (!enable) begin
            st_d   = IDLE;
            hold_d = 1'b0;
            we_d   = 1'b0;
            err_d  = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q    <= R_IDLE;
            sync_q  <= '1;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rxv_q   <= 1'b0;
            rxf_q   <= 1'b0;
            st_q    <= IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b0;
            err_q   <= 2'd0;
        end else begin
            rs_q    <= rs_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rxv_q   <= rxv_d;
            rxf_q   <= rxf_d;
            st_q    <= st_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end
endmodule
